// File: rtl/apb_irq_vector_arb.sv
// APB-programmable priority arbiter and interrupt vectoring controller.
// Selects the highest-priority enabled source, raises a registered active-low
// interrupt and hands out the winning ID through a read-to-acknowledge VECTOR
// register. In-service levels are tracked until software writes EOI.
// Build option: define IRQ_NESTING_EN for a 4-level nesting bitmap; otherwise a
// single in-service flag blocks all new interrupts until EOI.
module apb_irq_vector_arb (
  input  logic       PCLK,
  input  logic       nRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:2] PADDR,
  input  logic [7:0] PWDATA,
  input  logic [7:0] IRQSTAT,
  output logic [7:0] PRDATA,
  output logic       nIRQ
);

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned PRIO_W  = 2;

  localparam logic [3:0] ADDR_PRIO0  = 4'h0;
  localparam logic [3:0] ADDR_PRIO1  = 4'h1;
  localparam logic [3:0] ADDR_VECTOR = 4'h2;
  localparam logic [3:0] ADDR_EOI    = 4'h3;
  localparam logic [3:0] ADDR_ISTAT  = 4'h4;

  typedef enum logic [1:0] {StIdle, StPend, StHold} state_e;

  state_e              r_state;
  logic [7:0]          r_prio0;
  logic [7:0]          r_prio1;
  logic                r_win_valid;
  logic [2:0]          r_win_id;
  logic                r_nirq;
  logic [7:0]          r_prdata;

  logic [3:0]          w_addr;
  logic                w_wr;
  logic                w_rd_setup;
  logic                w_vec_setup;
  logic                w_eoi;
  logic [15:0]         w_prio_all;
  logic                w_cand_any;
  logic [2:0]          w_cand_id;
  logic [PRIO_W-1:0]   w_cand_prio;
  logic                w_cur_valid;
  logic [1:0]          w_cur_lvl;
  logic [3:0]          w_isr_view;
  logic                w_elig;
  logic [7:0]          w_rdata;
  logic                w_unused_paddr;

  assign w_addr         = PADDR[5:2];
  assign w_unused_paddr = ^PADDR[7:6];
  assign w_wr           = PSEL & PWRITE & PENABLE;
  assign w_rd_setup     = PSEL & ~PWRITE & ~PENABLE;
  assign w_vec_setup    = w_rd_setup & (w_addr == ADDR_VECTOR);
  assign w_eoi          = w_wr & (w_addr == ADDR_EOI);
  assign w_prio_all     = {r_prio1, r_prio0};

  // Candidate: highest priority among set sources; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_cand_any  = 1'b0;
    w_cand_id   = 3'd0;
    w_cand_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (IRQSTAT[i] && (!w_cand_any || (w_prio_all[2*i +: 2] > w_cand_prio))) begin
        w_cand_any  = 1'b1;
        w_cand_id   = 3'(i);
        w_cand_prio = w_prio_all[2*i +: 2];
      end
    end
  end

`ifdef IRQ_NESTING_EN
  logic [3:0] r_isr;
  logic [1:0] w_win_prio;

  // The winner's priority is looked up from its ID; no PRIO write can land between
  // the VECTOR setup phase and HOLD because APB is single-transfer.
  assign w_win_prio = w_prio_all[{r_win_id, 1'b0} +: 2];

  // Running level is the highest in-service bit.
  always_comb begin
    w_cur_lvl = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r_isr[i]) w_cur_lvl = 2'(i);
    end
  end

  assign w_cur_valid = |r_isr;
  assign w_isr_view  = r_isr;
  assign w_elig      = w_cand_any & (~w_cur_valid | (w_cand_prio > w_cur_lvl));

  // Acknowledge marks the winner's level in service; EOI retires the highest level.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_isr <= 4'h0;
    end else if (r_state == StHold) begin
      r_isr <= r_isr | (4'b0001 << w_win_prio);
    end else if (w_eoi) begin
      r_isr <= r_isr & ~(4'b0001 << w_cur_lvl);
    end
  end
`else
  logic r_isr;

  assign w_cur_valid = r_isr;
  assign w_cur_lvl   = 2'd0;
  assign w_isr_view  = {3'b000, r_isr};
  assign w_elig      = w_cand_any & ~r_isr;

  // Single in-service flag: set on acknowledge, cleared by EOI.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_isr <= 1'b0;
    end else if (r_state == StHold) begin
      r_isr <= 1'b1;
    end else if (w_eoi) begin
      r_isr <= 1'b0;
    end
  end
`endif

  // Priority register writes.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_prio0 <= 8'h00;
      r_prio1 <= 8'h00;
    end else if (w_wr) begin
      if (w_addr == ADDR_PRIO0) r_prio0 <= PWDATA;
      if (w_addr == ADDR_PRIO1) r_prio1 <= PWDATA;
    end
  end

  // Read data mux; unmapped and write-only offsets read as zero.
  always_comb begin
    w_rdata = 8'h00;
    case (w_addr)
      ADDR_PRIO0:  w_rdata = r_prio0;
      ADDR_PRIO1:  w_rdata = r_prio1;
      ADDR_VECTOR: w_rdata = r_win_valid ? {1'b1, 4'b0000, r_win_id} : 8'h00;
      ADDR_ISTAT:  w_rdata = {w_isr_view, 1'b0, w_cur_valid, w_cur_lvl};
      default:     w_rdata = 8'h00;
    endcase
  end

  // PRDATA captured at the setup-phase edge, zero otherwise.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_prdata <= 8'h00;
    end else begin
      r_prdata <= w_rd_setup ? w_rdata : 8'h00;
    end
  end

  // Vectoring FSM with registered winner and interrupt output.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state     <= StIdle;
      r_win_valid <= 1'b0;
      r_win_id    <= 3'd0;
      r_nirq      <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          r_win_valid <= w_elig;
          r_win_id    <= w_cand_id;
          r_nirq      <= ~w_elig;
          if (w_elig) r_state <= StPend;
        end
        StPend: begin
          // A VECTOR read wins over a same-cycle deassert so the returned ID is the one acked.
          if (w_vec_setup) begin
            r_state <= StHold;
            r_nirq  <= 1'b0;
          end else if (!w_elig) begin
            r_state     <= StIdle;
            r_win_valid <= 1'b0;
            r_nirq      <= 1'b1;
          end else begin
            r_win_id <= w_cand_id;
            r_nirq   <= 1'b0;
          end
        end
        StHold: begin
          r_state     <= StIdle;
          r_win_valid <= 1'b0;
          r_nirq      <= 1'b1;
        end
        default: begin
          r_state     <= StIdle;
          r_win_valid <= 1'b0;
          r_nirq      <= 1'b1;
        end
      endcase
    end
  end

  assign PRDATA = r_prdata;
  assign nIRQ   = r_nirq;

endmodule

// File: tb/tb_apb_irq_vector_arb.sv
// Self-checking bench for apb_irq_vector_arb: directed table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_apb_irq_vector_arb;

  logic       PCLK;
  logic       nRESET;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:2] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] IRQSTAT;
  logic [7:0] PRDATA;
  logic       nIRQ;

  apb_irq_vector_arb u_dut (
    .PCLK    (PCLK),
    .nRESET  (nRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .IRQSTAT (IRQSTAT),
    .PRDATA  (PRDATA),
    .nIRQ    (nIRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_wr(input logic [1:0] hi, input logic [3:0] off, input logic [7:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {hi, off}; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [1:0] hi, input logic [3:0] off, output logic [7:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {hi, off};
    tick();
    d = PRDATA;
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int         m_prio [8];
  logic [7:0] m_irq;
  logic [3:0] m_isr;

  function automatic void m_cand(output bit found, output int id, output int p);
    found = 1'b0; id = 0; p = 0;
    for (int lv = 3; lv >= 0; lv--) begin
      for (int s = 0; s < 8; s++) begin
        if (!found && m_irq[s] && m_prio[s] == lv) begin
          found = 1'b1; id = s; p = lv;
        end
      end
    end
  endfunction

  function automatic int m_top();
    int t = 0;
    for (int b = 0; b < 4; b++) if (m_isr[b]) t = b;
    return t;
  endfunction

  function automatic bit m_elig(output int id, output int p);
    bit f;
    m_cand(f, id, p);
    if (!f) return 1'b0;
`ifdef IRQ_NESTING_EN
    if (m_isr == 4'h0) return 1'b1;
    return p > m_top();
`else
    return m_isr == 4'h0;
`endif
  endfunction

  function automatic logic [7:0] m_istat();
`ifdef IRQ_NESTING_EN
    return {m_isr, 1'b0, m_isr != 4'h0, 2'(m_top())};
`else
    return {3'b000, m_isr[0], 1'b0, m_isr[0], 2'b00};
`endif
  endfunction

  function automatic logic [7:0] m_prio_reg(input int base);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(m_prio[base + i]);
    return v;
  endfunction

  // ---------------- directed table ----------------
  localparam logic [1:0] K_IRQ = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;

`ifdef IRQ_NESTING_EN
  localparam logic [7:0] ISTAT_PS = 8'h87;
`else
  localparam logic [7:0] ISTAT_PS = 8'h14;
`endif

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] off;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_nirq;
  } vec_t;

  vec_t       tbl [$];
  logic [7:0] rd;
  int         id, p, op, sel;
  bit         e;
  logic [7:0] d;
  logic [3:0] off;

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = 8'h00;
    IRQSTAT = 8'h00; nRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset nIRQ", {7'b0, nIRQ}, 8'h01);
    chk("reset PRDATA", PRDATA, 8'h00);
    nRESET = 1'b1;
    tick();

    // Reset defaults, priority select, tie, unmapped offset.
    tbl.push_back('{K_RD,  4'h0, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h1, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h2, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h4, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h0, 8'h40, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h1, 8'h0C, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h0, 8'h00, 8'h40, 1'b1});
    tbl.push_back('{K_RD,  4'h1, 8'h00, 8'h0C, 1'b1});
    tbl.push_back('{K_IRQ, 4'h0, 8'h28, 8'h00, 1'b0});
    tbl.push_back('{K_RD,  4'h2, 8'h00, 8'h85, 1'b1});
    tbl.push_back('{K_RD,  4'h4, 8'h00, ISTAT_PS, 1'b1});
    tbl.push_back('{K_WR,  4'h3, 8'hFF, 8'h00, 1'b0});
    tbl.push_back('{K_RD,  4'h2, 8'h00, 8'h85, 1'b1});
    tbl.push_back('{K_IRQ, 4'h0, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h3, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h4, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h9, 8'h55, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h9, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h0, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h1, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_IRQ, 4'h0, 8'h06, 8'h00, 1'b0});
    tbl.push_back('{K_RD,  4'h2, 8'h00, 8'h81, 1'b1});
    tbl.push_back('{K_RD,  4'h4, 8'h00, 8'h14, 1'b1});
    tbl.push_back('{K_IRQ, 4'h0, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_WR,  4'h3, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{K_RD,  4'h4, 8'h00, 8'h00, 1'b1});

    foreach (tbl[i]) begin
      rd = 8'h00;
      case (tbl[i].kind)
        K_IRQ:   IRQSTAT = tbl[i].data;
        K_WR:    apb_wr(2'b00, tbl[i].off, tbl[i].data);
        default: apb_rd(2'b00, tbl[i].off, rd);
      endcase
      tick();
      if (tbl[i].kind == K_RD) chk($sformatf("tbl[%0d] rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl[%0d] nIRQ", i), {7'b0, nIRQ}, {7'b0, tbl[i].exp_nirq});
      chk($sformatf("tbl[%0d] PRDATA idle", i), PRDATA, 8'h00);
    end

    // Exact nIRQ latency and deassert at the acknowledge edge.
    apb_wr(2'b00, 4'h0, 8'h40);
    apb_wr(2'b00, 4'h1, 8'h0C);
    IRQSTAT = 8'h28;
    #1 chk("lat before edge", {7'b0, nIRQ}, 8'h01);
    tick();
    chk("lat after edge", {7'b0, nIRQ}, 8'h00);
    apb_rd(2'b00, 4'h2, rd);
    chk("lat vector", rd, 8'h85);
    chk("lat ack deassert", {7'b0, nIRQ}, 8'h01);
    IRQSTAT = 8'h00;
    apb_wr(2'b00, 4'h3, 8'h00);
    tick();

    // Preemption / blocking while src3 is in service.
    IRQSTAT = 8'h08;
    tick();
    chk("pre src3 nIRQ", {7'b0, nIRQ}, 8'h00);
    apb_rd(2'b00, 4'h2, rd);
    chk("pre src3 vector", rd, 8'h83);
    IRQSTAT = 8'h28;
    tick(); tick();
`ifdef IRQ_NESTING_EN
    chk("pre src5 nIRQ", {7'b0, nIRQ}, 8'h00);
    apb_rd(2'b00, 4'h2, rd);
    chk("pre src5 vector", rd, 8'h85);
    apb_rd(2'b00, 4'h4, rd);
    chk("pre istat A", rd, 8'hA7);
    IRQSTAT = 8'h00;
    apb_wr(2'b00, 4'h3, 8'h00);
    apb_rd(2'b00, 4'h4, rd);
    chk("pre istat after eoi1", rd, 8'h25);
    apb_wr(2'b00, 4'h3, 8'h00);
    apb_rd(2'b00, 4'h4, rd);
    chk("pre istat after eoi2", rd, 8'h00);
`else
    chk("blk src5 nIRQ", {7'b0, nIRQ}, 8'h01);
    apb_wr(2'b00, 4'h3, 8'h00);
    tick();
    chk("blk src5 after eoi", {7'b0, nIRQ}, 8'h00);
    apb_rd(2'b00, 4'h2, rd);
    chk("blk src5 vector", rd, 8'h85);
    IRQSTAT = 8'h00;
    apb_wr(2'b00, 4'h3, 8'h00);
    apb_rd(2'b00, 4'h4, rd);
    chk("blk istat clear", rd, 8'h00);
`endif

    // No preemption from a lower level; EOI releases it one edge later.
    IRQSTAT = 8'h20;
    tick();
    apb_rd(2'b00, 4'h2, rd);
    chk("nop src5 vector", rd, 8'h85);
    IRQSTAT = 8'h01;
    tick(); tick();
    chk("nop held off", {7'b0, nIRQ}, 8'h01);
    apb_wr(2'b00, 4'h3, 8'h00);
    chk("nop at eoi edge", {7'b0, nIRQ}, 8'h01);
    tick();
    chk("nop next edge", {7'b0, nIRQ}, 8'h00);
    apb_rd(2'b00, 4'h2, rd);
    chk("nop src0 vector", rd, 8'h80);
    IRQSTAT = 8'h00;
    apb_wr(2'b00, 4'h3, 8'h00);
    tick();

    // Spurious read after the source goes away.
    IRQSTAT = 8'h04;
    tick();
    chk("spur asserted", {7'b0, nIRQ}, 8'h00);
    IRQSTAT = 8'h00;
    tick();
    chk("spur released", {7'b0, nIRQ}, 8'h01);
    apb_rd(2'b00, 4'h2, rd);
    chk("spur vector", rd, 8'h00);
    apb_rd(2'b00, 4'h4, rd);
    chk("spur istat", rd, 8'h00);

    // Reset during the HOLD access phase.
    IRQSTAT = 8'h04;
    tick();
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 6'h02;
    tick();
    chk("rst pre PRDATA", PRDATA, 8'h82);
    PENABLE = 1'b1;
    #2 nRESET = 1'b0;
    #1;
    chk("rst nIRQ", {7'b0, nIRQ}, 8'h01);
    chk("rst PRDATA", PRDATA, 8'h00);
    PSEL = 1'b0; PENABLE = 1'b0; IRQSTAT = 8'h00;
    tick();
    nRESET = 1'b1;
    tick();
    apb_rd(2'b00, 4'h4, rd);
    chk("rst istat", rd, 8'h00);
    apb_rd(2'b00, 4'h1, rd);
    chk("rst prio1", rd, 8'h00);

    // Randomized run against the model, starting from a clean reset.
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) m_prio[i] = 0;
    m_irq = 8'h00;
    m_isr = 4'h0;
    for (int it = 0; it < 600; it++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: begin
          m_irq = (op == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
          IRQSTAT = m_irq;
          tick();
        end
        2: begin
          sel = int'($urandom_range(0, 1));
          d = 8'($urandom);
          apb_wr(2'($urandom), 4'(sel), d);
          for (int k = 0; k < 4; k++) m_prio[4*sel + k] = int'(d[2*k +: 2]);
        end
        3: begin
          apb_wr(2'($urandom), 4'h3, 8'($urandom));
`ifdef IRQ_NESTING_EN
          if (m_isr != 4'h0) m_isr[m_top()] = 1'b0;
`else
          m_isr = 4'h0;
`endif
        end
        4, 5: begin
          e = m_elig(id, p);
          apb_rd(2'($urandom), 4'h2, rd);
          chk($sformatf("rnd[%0d] vector", it), rd, e ? {5'b10000, 3'(id)} : 8'h00);
          if (e) begin
`ifdef IRQ_NESTING_EN
            m_isr[p] = 1'b1;
`else
            m_isr = 4'h1;
`endif
          end
        end
        6: begin
          apb_rd(2'($urandom), 4'h4, rd);
          chk($sformatf("rnd[%0d] istat", it), rd, m_istat());
        end
        7: begin
          sel = int'($urandom_range(0, 1));
          apb_rd(2'($urandom), 4'(sel), rd);
          chk($sformatf("rnd[%0d] prio%0d", it, sel), rd, m_prio_reg(4*sel));
        end
        8: begin
          off = 4'($urandom_range(5, 15));
          apb_rd(2'($urandom), off, rd);
          chk($sformatf("rnd[%0d] unmapped rd", it), rd, 8'h00);
        end
        default: begin
          off = 4'($urandom_range(5, 15));
          apb_wr(2'($urandom), off, 8'($urandom));
        end
      endcase
      tick();
      e = m_elig(id, p);
      chk($sformatf("rnd[%0d] nIRQ", it), {7'b0, nIRQ}, {7'b0, ~e});
      chk($sformatf("rnd[%0d] PRDATA idle", it), PRDATA, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
